// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared constants and types for the instruction fetch stage.
//   MEM_INSTR_ZERO : base address of instruction memory (default reset PC)
//   MEM_SIZE_B     : size of instruction memory in bytes
//   fetch_entry_t  : {pc, instr} pair handed from fetch to decode
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int          INSTR_W        = 32;
    localparam logic [31:0] MEM_INSTR_ZERO = 32'h0000_1000;
    localparam logic [31:0] MEM_SIZE_B     = 32'h0000_0400;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Valid/ready handshake from fetch to decode.
//   out_valid : head entry valid         (fetch -> decode)
//   out_ready : decode accepts the head  (decode -> fetch)
//   out_pc    : PC of the head entry     (fetch -> decode)
//   out_instr : head instruction word    (fetch -> decode)
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (output out_valid, output out_pc, output out_instr, input  out_ready);
    modport slave  (input  out_valid, input  out_pc, input  out_instr, output out_ready);

endinterface

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// instr_fetch_fifo
//   Circular FIFO of fetch entries with push, pop, flush and occupancy count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_push/i_entry: write an entry at the tail
//   i_pop         : drop the head entry
//   i_flush       : discard all entries (wins over push/pop)
//   o_head        : head entry (registered storage, zero after reset)
//   o_valid       : FIFO not empty
//   o_count       : number of stored entries
// -----------------------------------------------------------------------------
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) r_count <= CW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage: owns the PC, drives the instruction memory address, captures
//   the returned word one cycle later and buffers {pc, instr} for decode.
//   A redirect flushes everything in flight and restarts at the new PC.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   imem_addr_o    : read address (current PC)
//   imem_data_i    : word for the address presented in the previous cycle
//   redirect_i     : flush and restart fetch at redirect_pc_i (word aligned)
//   dec            : valid/ready output towards decode
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MEM_INSTR_ZERO,
    parameter int          DEPTH    = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic [31:0]        imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    instr_fetch_if.master      dec
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_occ;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;

    assign w_pop = w_valid & dec.out_ready;

    // Occupancy the FIFO would reach if the request in flight lands and the
    // head leaves this cycle; issue only when a slot is guaranteed. Ready
    // therefore feeds the PC increment combinationally.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign w_issue = !redirect_i && (w_occ < (CW + 1)'(DEPTH));

    // The memory reads every cycle; only the response to an issued request is kept.
    assign w_push  = r_inflight & !redirect_i;
    assign w_entry = '{pc: r_inflight_pc, instr: imem_data_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_i) begin
            r_pc       <= redirect_pc_i & ~32'h3;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    instr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign imem_addr_o   = r_pc;
    assign dec.out_valid = w_valid;
    assign dec.out_pc    = w_head.pc;
    assign dec.out_instr = w_head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] Z      = 32'h0000_1000;
    localparam logic [31:0] SIZE_B = 32'h0000_0400;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    logic [63:0] exp_q[$];

    instr_fetch_if dec_if ();

    instr_fetch #(.RESET_PC(Z), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .dec           (dec_if)
    );

    always #5 clk = ~clk;

    // Instruction memory: mem[i] = i inside [Z, Z+SIZE_B), zero elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= Z && a < Z + SIZE_B) return (a - Z) >> 2;
        return 32'h0;
    endfunction

    always @(posedge clk) imem_data <= mem_word(imem_addr);

    // Scoreboard monitor: every accepted head is compared with the queue front.
    always @(negedge clk) begin
        if (rst_n && dec_if.out_valid && dec_if.out_ready) begin
            logic [63:0] e;
            n_pop++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, want nothing", dec_if.out_pc, dec_if.out_instr);
            end else begin
                e = exp_q.pop_front();
                if ({dec_if.out_pc, dec_if.out_instr} !== e)
                begin
                    bad++;
                    $display("FAIL sb_entry: got pc=%h instr=%h, want pc=%h instr=%h",
                             dec_if.out_pc, dec_if.out_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] pc;
            pc = start + 32'(4 * i);
            exp_q.push_back({pc, mem_word(pc)});
        end
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (n_pop < target && k < budget) begin
            step();
            k++;
        end
        check32(name, 32'(n_pop >= target), 32'd1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the redirect edge.
    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        #1;
        exp_q.delete();
        push_stream(target & ~32'h3, 64);
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        dec_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_valid", 32'(dec_if.out_valid), 32'd0);
        check32("rst_pc", dec_if.out_pc, 32'h0);
        check32("rst_instr", dec_if.out_instr, 32'h0);
        check32("rst_addr", imem_addr, 32'h1000);

        // 1: reset release, streaming
        push_stream(Z, 64);
        rst_n = 1'b1;
        step();
        check32("t1_valid_e1", 32'(dec_if.out_valid), 32'd0);
        check32("t1_addr_e1", imem_addr, 32'h1004);
        step();
        check32("t1_valid_e2", 32'(dec_if.out_valid), 32'd1);
        check32("t1_pc_e2", dec_if.out_pc, 32'h1000);
        check32("t1_instr_e2", dec_if.out_instr, 32'h0);
        repeat (4) step();
        check32("t1_throughput", 32'(n_pop), 32'd4);
        check32("t1_head_pc", dec_if.out_pc, 32'h1010);

        // 2: backpressure
        dec_if.out_ready = 1'b0;
        repeat (5) step();
        check32("t2_count_full", 32'(dut.u_fifo.r_count), 32'(DEPTH));
        check32("t2_pc_frozen", imem_addr, 32'h1018);
        check32("t2_head_held", dec_if.out_pc, 32'h1010);
        check32("t2_no_pop", 32'(n_pop), 32'd4);
        dec_if.out_ready = 1'b1;
        wait_pops("t2_resume", 10, 20);

        // 3: redirect while full
        dec_if.out_ready = 1'b0;
        repeat (3) step();
        do_redirect(Z + 32'h100);
        dec_if.out_ready = 1'b1;
        check32("t3_valid_r0", 32'(dec_if.out_valid), 32'd0);
        check32("t3_addr_r0", imem_addr, 32'h1100);
        step();
        check32("t3_valid_r1", 32'(dec_if.out_valid), 32'd0);
        step();
        check32("t3_pc_r2", dec_if.out_pc, 32'h1100);
        check32("t3_instr_r2", dec_if.out_instr, 32'h40);
        base = n_pop;
        wait_pops("t3_stream", base + 4, 20);

        // 4: misaligned target, then back-to-back redirects
        do_redirect(Z + 32'h102);
        check32("t4_align", imem_addr, 32'h1100);
        step();
        step();
        check32("t4_pc_aligned", dec_if.out_pc, 32'h1100);
        do_redirect(Z + 32'h200);
        do_redirect(Z + 32'h300);
        step();
        step();
        check32("t4_last_wins_pc", dec_if.out_pc, 32'h1300);
        check32("t4_last_wins_instr", dec_if.out_instr, 32'hC0);
        base = n_pop;
        wait_pops("t4_stream", base + 5, 20);

        // 5: end of memory and PC wrap
        do_redirect(Z + SIZE_B - 32'h8);
        step();
        step();
        check32("t5_instr_last0", dec_if.out_instr, 32'hFE);
        step();
        check32("t5_instr_last1", dec_if.out_instr, 32'hFF);
        step();
        check32("t5_oor_pc", dec_if.out_pc, 32'h1400);
        check32("t5_oor_instr", dec_if.out_instr, 32'h0);
        do_redirect(32'hFFFF_FFFF);
        check32("t5_wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check32("t5_wrap_addr1", imem_addr, 32'h0);
        step();
        check32("t5_wrap_pc0", dec_if.out_pc, 32'hFFFF_FFFC);
        step();
        check32("t5_wrap_pc1", dec_if.out_pc, 32'h0);

        // 6: reset mid-stream with random ready
        for (int i = 0; i < 15; i++) begin
            dec_if.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check32("t6_rst_valid", 32'(dec_if.out_valid), 32'd0);
        check32("t6_rst_pc", dec_if.out_pc, 32'h0);
        check32("t6_rst_addr", imem_addr, 32'h1000);
        exp_q.delete();
        push_stream(Z, 64);
        step();
        step();
        rst_n = 1'b1;
        base = n_pop;
        step();
        check32("t6_valid_e1", 32'(dec_if.out_valid), 32'd0);
        step();
        check32("t6_valid_e2", 32'(dec_if.out_valid), 32'd1);
        check32("t6_pc_e2", dec_if.out_pc, 32'h1000);
        for (int i = 0; i < 30; i++) begin
            dec_if.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        dec_if.out_ready = 1'b1;
        wait_pops("t6_stream", base + 24, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
